// File: rtl/sev_seg_capture.sv
// Seven-segment capture: synchronises an active-low anode/segment bus, waits
// for a stable window, and decodes each digit back to its hex value.
module sev_seg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     err,
  output logic                  frame
);

  localparam int         W       = DIGITS + 7;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  logic [W-1:0]      s1, s2, prev;
  logic [7:0]        cnt;
  logic [DIGITS-1:0] mask;

  logic              capture;
  logic [DIGITS-1:0] sel;
  logic [DIGITS-1:0] hit;
  logic [DIGITS-1:0] mask_next;
  logic [3:0]        hex;
  logic              legal;
  logic              is_blank;

  // Synchroniser idles at all-ones so reset looks like a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
    end else begin
      s1   <= {an, seg};
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (s2 != prev) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    capture  = (s2 == prev) && (cnt == CNT_CAP);
    sel      = ~s2[W-1:7];
    hit      = (capture && $onehot(sel)) ? sel : '0;
    is_blank = (s2[6:0] == 7'h7F);
    legal    = 1'b1;
    hex      = 4'h0;
    case (s2[6:0])
      7'h01:   hex = 4'h0;
      7'h4F:   hex = 4'h1;
      7'h12:   hex = 4'h2;
      7'h06:   hex = 4'h3;
      7'h4C:   hex = 4'h4;
      7'h24:   hex = 4'h5;
      7'h20:   hex = 4'h6;
      7'h0F:   hex = 4'h7;
      7'h00:   hex = 4'h8;
      7'h04:   hex = 4'h9;
      7'h08:   hex = 4'hA;
      7'h60:   hex = 4'hB;
      7'h31:   hex = 4'hC;
      7'h42:   hex = 4'hD;
      7'h30:   hex = 4'hE;
      7'h38:   hex = 4'hF;
      default: legal = 1'b0;
    endcase
    mask_next = mask | hit;
  end

  // Completing the mask pulses frame and clears the mask on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      blank  <= '1;
      err    <= '0;
      frame  <= 1'b0;
      mask   <= '0;
    end else begin
      frame <= &mask_next;
      mask  <= (&mask_next) ? '0 : mask_next;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (hit[i]) begin
          if (legal) begin
            digits[4*i +: 4] <= hex;
            blank[i]         <= 1'b0;
            err[i]           <= 1'b0;
          end else if (is_blank) begin
            blank[i] <= 1'b1;
            err[i]   <= 1'b0;
          end else begin
            blank[i] <= 1'b0;
            err[i]   <= 1'b1;
          end
        end
      end
    end
  end

endmodule
